// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - serialises core ibus/dbus requests onto one single-beat cbus port
// Package carries the bus structs shared with the core, memory side and bench.
package core_bus_arbiter_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] mlen_t;
  typedef logic [1:0] axi_burst_t;
  localparam mlen_t      MLEN1           = 8'd0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_IBUSY, S_DBUSY} state_t;

  localparam logic [31:0] LP_TO = 32'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  cbus_req_t   r_creq;
  cbus_req_t   w_creq_map;
  logic        r_last_d;
  logic [31:0] r_cnt;
  logic        w_grant_d;
  logic        w_done;
  logic        w_busy;

  assign w_done = cresp.ready & cresp.last;
  assign w_busy = (r_state != S_IDLE);
  assign creq   = r_creq;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Without DATA_FIRST the previous loser wins a tie.
        if (dreq.valid && ireq.valid) w_grant_d = DATA_FIRST || !r_last_d;
        else                          w_grant_d = dreq.valid;
        if (dreq.valid || ireq.valid) w_next_state = w_grant_d ? S_DBUSY : S_IBUSY;
      end
      S_IBUSY, S_DBUSY: if (w_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_creq_map       = '0;
    w_creq_map.valid = 1'b1;
    w_creq_map.len   = MLEN1;
    w_creq_map.burst = AXI_BURST_FIXED;
    if (w_grant_d) begin
      w_creq_map.is_write = |dreq.strobe;
      w_creq_map.size     = dreq.size;
      w_creq_map.addr     = dreq.addr;
      w_creq_map.strobe   = dreq.strobe;
      w_creq_map.data     = dreq.data;
    end else begin
      w_creq_map.size = MSIZE4;
      w_creq_map.addr = ireq.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_creq   <= '0;
      r_last_d <= 1'b0;
    end else if (!w_busy && w_next_state != S_IDLE) begin
      r_creq <= w_creq_map;
    end else if (w_busy && w_done) begin
      r_creq.valid <= 1'b0;
      r_last_d     <= (r_state == S_DBUSY);
    end
  end

  // Saturates at TIMEOUT so the error pulses only once per transaction.
  always_ff @(posedge clk) begin
    if (reset || !w_busy)  r_cnt <= 32'd0;
    else if (r_cnt != LP_TO) r_cnt <= r_cnt + 32'd1;
  end

  always_comb begin
    iresp       = '0;
    dresp       = '0;
    timeout_err = (LP_TO != 32'd0) && w_busy && (r_cnt == LP_TO - 32'd1);
    if (r_state == S_IBUSY && w_done) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = r_creq.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
    end
    if (r_state == S_DBUSY && w_done) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - directed-vector bench for core_bus_arbiter
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq_a, ireq_b;
  ibus_resp_t iresp_a, iresp_b;
  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t dresp_a, dresp_b;
  cbus_req_t  creq_a, creq_b;
  cbus_resp_t cresp_a, cresp_b;
  logic       terr_a, terr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_bus_arbiter #(.DATA_FIRST(1'b1), .TIMEOUT(1023)) u_dut_a (
    .clk(clk), .reset(reset), .ireq(ireq_a), .iresp(iresp_a), .dreq(dreq_a),
    .dresp(dresp_a), .creq(creq_a), .cresp(cresp_a), .timeout_err(terr_a)
  );

  core_bus_arbiter #(.DATA_FIRST(1'b0), .TIMEOUT(1023)) u_dut_b (
    .clk(clk), .reset(reset), .ireq(ireq_b), .iresp(iresp_b), .dreq(dreq_b),
    .dresp(dresp_b), .creq(creq_b), .cresp(cresp_b), .timeout_err(terr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  cbus_req_t saved;
  int        pulses, pcyc, changes;
  int        exp_addr [4] = '{32'h200, 32'h100, 32'h200, 32'h100};

  initial begin
    reset = 1'b1;
    ireq_a = '0; dreq_a = '0; cresp_a = '0;
    ireq_b = '0; dreq_b = '0; cresp_b = '0;
    tick(); tick();
    chk("rst_creq", creq_a, '0);
    chk("rst_iresp", iresp_a, '0);
    chk("rst_dresp", dresp_a, '0);
    chk("rst_terr", terr_a, 1'b0);
    reset = 1'b0;

    // 1: instruction fetch, memory answers on the third busy cycle
    tick();
    ireq_a.valid = 1'b1; ireq_a.addr = 64'h8000_0004;
    #1 chk("t1_t0_creq_valid", creq_a.valid, 1'b0);
    tick();
    chk("t1_t1_creq_valid", creq_a.valid, 1'b1);
    chk("t1_size", creq_a.size, MSIZE4);
    chk("t1_is_write", creq_a.is_write, 1'b0);
    chk("t1_addr", creq_a.addr, 64'h8000_0004);
    chk("t1_no_early_ok", iresp_a.data_ok, 1'b0);
    tick(); tick();
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'h1111_2222_3333_4444};
    #1;
    chk("t1_data_ok", iresp_a.data_ok, 1'b1);
    chk("t1_data", iresp_a.data, 32'h1111_2222);
    chk("t1_dresp_quiet", dresp_a, '0);
    tick();
    cresp_a = '0; ireq_a.valid = 1'b0;
    #1;
    chk("t1_after_valid", creq_a.valid, 1'b0);
    chk("t1_after_ok", iresp_a.data_ok, 1'b0);

    // 2: simultaneous requests with data priority
    tick();
    ireq_a.valid = 1'b1; ireq_a.addr = 64'h8000_0010;
    dreq_a.valid = 1'b1; dreq_a.addr = 64'h8000_1000; dreq_a.strobe = 8'hFF;
    dreq_a.size = MSIZE8; dreq_a.data = 64'hDEAD_BEEF_0000_0001;
    tick();
    chk("t2_d_valid", creq_a.valid, 1'b1);
    chk("t2_is_write", creq_a.is_write, 1'b1);
    chk("t2_d_addr", creq_a.addr, 64'h8000_1000);
    chk("t2_d_strobe", creq_a.strobe, 8'hFF);
    chk("t2_d_wdata", creq_a.data, 64'hDEAD_BEEF_0000_0001);
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    #1;
    chk("t2_d_ok", dresp_a.data_ok, 1'b1);
    chk("t2_i_quiet", iresp_a.data_ok, 1'b0);
    tick();
    cresp_a = '0; dreq_a = '0;
    #1 chk("t2_idle_gap", creq_a.valid, 1'b0);
    tick();
    chk("t2_i_valid", creq_a.valid, 1'b1);
    chk("t2_i_addr", creq_a.addr, 64'h8000_0010);
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'hAAAA_BBBB_CCCC_DDDD};
    #1;
    chk("t2_i_ok", iresp_a.data_ok, 1'b1);
    chk("t2_i_data", iresp_a.data, 32'hCCCC_DDDD);
    tick();
    cresp_a = '0; ireq_a = '0;

    // 3: strict alternation, both masters continuously valid
    ireq_b.valid = 1'b1; ireq_b.addr = 64'h100;
    dreq_b.valid = 1'b1; dreq_b.addr = 64'h200;
    cresp_b = '{ready: 1'b1, last: 1'b1, data: 64'h5};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_valid_%0d", k), creq_b.valid, 1'b1);
      chk($sformatf("t3_grant_%0d", k), creq_b.addr, 64'(exp_addr[k]));
      tick();
      chk($sformatf("t3_gap_%0d", k), creq_b.valid, 1'b0);
    end
    ireq_b = '0; dreq_b = '0; cresp_b = '0;
    tick();

    // 4: stalled memory trips the timeout exactly once
    dreq_a.valid = 1'b1; dreq_a.addr = 64'h8000_2000; dreq_a.strobe = 8'h0F;
    dreq_a.size = MSIZE4; dreq_a.data = 64'h1234;
    tick();
    saved = creq_a;
    chk("t4_is_write", saved.is_write, 1'b1);
    pulses = 0; pcyc = 0; changes = 0;
    for (int n = 1; n <= 1100; n++) begin
      if (n > 1) tick();
      if (terr_a) begin
        pulses++;
        pcyc = n;
      end
      if (creq_a !== saved) changes++;
    end
    chk("t4_pulses", 64'(pulses), 64'd1);
    chk("t4_pulse_cycle", 64'(pcyc), 64'd1023);
    chk("t4_creq_stable", 64'(changes), 64'd0);
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'h77};
    #1;
    chk("t4_late_ok", dresp_a.data_ok, 1'b1);
    chk("t4_late_data", dresp_a.data, 64'h77);
    tick();
    cresp_a = '0; dreq_a = '0;
    tick();

    // 5: reset while a data transaction is stalled
    dreq_a.valid = 1'b1; dreq_a.addr = 64'h8000_3000; dreq_a.strobe = 8'h01;
    tick();
    chk("t5_busy", creq_a.valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5_creq_cleared", creq_a.valid, 1'b0);
    chk("t5_no_ok", dresp_a.data_ok, 1'b0);
    reset = 1'b0; dreq_a = '0;
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'h99};
    #1 chk("t5_late_ignored", dresp_a.data_ok, 1'b0);
    tick();
    cresp_a = '0;
    tick();

    // 6: byte read
    dreq_a.valid = 1'b1; dreq_a.addr = 64'h8000_0003; dreq_a.size = MSIZE1; dreq_a.strobe = 8'h00;
    tick();
    chk("t6_is_write", creq_a.is_write, 1'b0);
    chk("t6_size", creq_a.size, MSIZE1);
    chk("t6_addr", creq_a.addr, 64'h8000_0003);
    cresp_a = '{ready: 1'b1, last: 1'b1, data: 64'h0123_4567_89AB_CDEF};
    #1;
    chk("t6_ok", dresp_a.data_ok, 1'b1);
    chk("t6_data", dresp_a.data, 64'h0123_4567_89AB_CDEF);
    tick();
    cresp_a = '0; dreq_a = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
